// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the tick_gen block.
// Channel index width and maximum channel count live here.
package tick_gen_pkg;

    localparam int TG_CNT_W  = 26;
    localparam int TG_IDX_W  = 4;
    localparam int TG_MAX_CH = 16;

    typedef enum logic [1:0] {
        CH_HOLD,
        CH_COUNT,
        CH_SYNC,
        CH_LOAD
    } ch_op_e;

    function automatic ch_op_e ch_op(
        input logic sync,
        input logic load,
        input logic en
    );
        if (sync) return CH_SYNC;
        if (load) return CH_LOAD;
        if (en)   return CH_COUNT;
        return CH_HOLD;
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Control/observation bundle for tick_gen.
// master drives the strobes and divisor bus, slave returns tick/sq.
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = TG_CNT_W
);
    logic                en;
    logic                sync;
    logic                load;
    logic [TG_IDX_W-1:0] load_ch;
    logic [CNT_W-1:0]    load_div;
    logic [N_CH-1:0]     tick;
    logic [N_CH-1:0]     sq;

    modport master (
        output en,
        output sync,
        output load,
        output load_ch,
        output load_div,
        input  tick,
        input  sq
    );

    modport slave (
        input  en,
        input  sync,
        input  load,
        input  load_ch,
        input  load_div,
        output tick,
        output sq
    );
endinterface

// File: rtl/tick_gen_ch.sv
// One tick channel: divisor, counter, tick pulse and optional square wave.
// Square-wave flops exist only when TICK_GEN_SQUARE_EN is defined.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int          CNT_W   = TG_CNT_W,
    parameter int unsigned DIV_RST = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             sq
);

    localparam logic [CNT_W-1:0] DIV_INIT = DIV_RST[CNT_W-1:0];

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] last;
    logic             wrap;
    ch_op_e           op;

    // A zero divisor behaves as one: terminal count is then 0.
    always_comb begin
        last = (div_q == '0) ? '0 : div_q - 1'b1;
        wrap = (cnt_q == last);
        op   = ch_op(sync, load, en);
    end

    always_comb begin
        div_d  = load ? load_div : div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        case (op)
            CH_SYNC,
            CH_LOAD:  cnt_d = '0;
            CH_COUNT: begin
                cnt_d  = wrap ? '0 : cnt_q + 1'b1;
                tick_d = wrap;
            end
            default:  cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= DIV_INIT;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef TICK_GEN_SQUARE_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = sq_q;
        case (op)
            CH_SYNC:  sq_d = 1'b0;
            CH_COUNT: sq_d = sq_q ^ wrap;
            default:  sq_d = sq_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: load decode and sync fan-out.
// Define TICK_GEN_SQUARE_EN to build the per-channel square-wave outputs.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned CLK_XTAL = 50000000,
    parameter int          N_CH     = 4,
    parameter int          CNT_W    = TG_CNT_W,
    parameter int unsigned DIV_RST  = CLK_XTAL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sync,
    input  logic                load,
    input  logic [TG_IDX_W-1:0] load_ch,
    input  logic [CNT_W-1:0]    load_div,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     sq
);

    logic [N_CH-1:0] ld_hit;

    // Out-of-range indices match no channel and are dropped.
    always_comb begin
        ld_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            ld_hit[i] = load && (load_ch == TG_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_gen_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .sync     (sync),
            .load     (ld_hit[g]),
            .load_div (load_div),
            .tick     (tick[g]),
            .sq       (sq[g])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed self-checking bench for tick_gen (DIV_RST=8, CNT_W=8, N_CH=4).
// sq expectations follow TICK_GEN_SQUARE_EN.
module tb_tick_gen;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;

`ifdef TICK_GEN_SQUARE_EN
    localparam logic SQ_ON = 1'b1;
`else
    localparam logic SQ_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tick_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    tick_gen #(
        .CLK_XTAL (8),
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DIV_RST  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .sync     (bus.sync),
        .load     (bus.load),
        .load_ch  (bus.load_ch),
        .load_div (bus.load_div),
        .tick     (bus.tick),
        .sq       (bus.sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input int ch, input int dv);
        bus.load     = 1'b1;
        bus.load_ch  = 4'(ch);
        bus.load_div = 8'(dv);
        cyc();
        bus.load     = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        bus.en       = 1'b0;
        bus.sync     = 1'b0;
        bus.load     = 1'b0;
        bus.load_ch  = '0;
        bus.load_div = '0;
        #2;
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_sq", 32'(bus.sq), 0);
        cyc();
        cyc();
        rst = 1'b1;

        // divisor 4 on channel 0
        bus.en = 1'b1;
        do_load(0, 4);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("div4_tick0_k%0d", k),
                32'(bus.tick[0]), 32'((k % 4) == 0));
            chk($sformatf("div4_sq0_k%0d", k),
                32'(bus.sq[0]), 32'(SQ_ON & (((k / 4) % 2) == 1)));
        end

        // divisors 0 and 1 on channel 1
        do_load(1, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("div0_tick1_k%0d", k), 32'(bus.tick[1]), 1);
        end
        do_load(1, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("div1_tick1_k%0d", k), 32'(bus.tick[1]), 1);
        end
        bus.en = 1'b0;
        cyc();
        chk("en0_tick1", 32'(bus.tick[1]), 0);
        bus.en = 1'b1;

        // divisors 3 and 5, phase-aligned by sync
        do_load(0, 3);
        do_load(1, 5);
        cyc();
        cyc();
        cyc();
        bus.sync = 1'b1;
        cyc();
        bus.sync = 1'b0;
        chk("sync_tick", 32'(bus.tick[1:0]), 0);
        chk("sync_sq", 32'(bus.sq[1:0]), 0);
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk($sformatf("sync_tick_k%0d", k), 32'(bus.tick[1:0]),
                32'({(k % 5) == 0, (k % 3) == 0}));
        end
        chk("sync_sq_k15", 32'(bus.sq[1:0]), 32'({SQ_ON, SQ_ON}));

        // sync and load together
        bus.sync = 1'b1;
        do_load(2, 2);
        bus.sync = 1'b0;
        chk("syncld_tick", 32'(bus.tick), 0);
        cyc();
        chk("syncld_k1", 32'(bus.tick[2]), 0);
        cyc();
        chk("syncld_k2", 32'(bus.tick[2]), 1);

        // pause at cnt=2 with divisor 6
        do_load(0, 6);
        cyc();
        cyc();
        bus.en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("pause_tick0_k%0d", k), 32'(bus.tick[0]), 0);
        end
        bus.en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("resume_tick0_k%0d", k),
                32'(bus.tick[0]), 32'(k == 4));
        end

        // out-of-range load must not disturb channel 0
        bus.load     = 1'b1;
        bus.load_ch  = 4'(N_CH);
        bus.load_div = 8'd7;
        for (int k = 5; k <= 10; k++) begin
            cyc();
            bus.load = 1'b0;
            chk($sformatf("oor_tick0_k%0d", k),
                32'(bus.tick[0]), 32'(k == 10));
        end

        // asynchronous reset between edges
        do_load(3, 0);
        cyc();
        chk("pre_rst_tick3", 32'(bus.tick[3]), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_tick", 32'(bus.tick), 0);
        chk("async_rst_sq", 32'(bus.sq), 0);
        cyc();
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("post_rst_tick_k%0d", k), 32'(bus.tick),
                (k == 8) ? 32'hF : 32'h0);
        end
        chk("post_rst_sq", 32'(bus.sq), 32'({4{SQ_ON}}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter CLK_XTAL, default 50000000: input clock frequency in Hz, documentation and default-divisor use only.
REQ-002 SHALL have parameter N_CH, default 4: number of independent tick channels, range 1..16.
REQ-003 SHALL have parameter CNT_W, default 26: divisor and counter width in bits.
REQ-004 SHALL have parameter DIV_RST, default 50000000: divisor loaded into every channel at reset.
REQ-005 SHALL have port clk  in  1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port en  in  1: global count enable.
REQ-008 SHALL have port sync  in  1: one-cycle strobe that restarts all channels phase-aligned.
REQ-009 SHALL have port load  in  1: divisor write strobe.
REQ-010 SHALL have port load_ch  in  4: channel index for the divisor write.
REQ-011 SHALL have port load_div  in  CNT_W: new divisor value.
REQ-012 SHALL have port tick  out  N_CH: per-channel registered one-cycle pulse.
REQ-013 SHALL have port sq  out  N_CH: per-channel registered square wave with period 2*divisor.

Function
REQ-014 Each channel SHALL hold a divisor register div[i] and a counter cnt[i], both CNT_W bits wide.
REQ-015 Effective divisor SHALL be max(div[i],1); a divisor of 0 behaves as 1, giving a tick every enabled cycle.
REQ-016 With en=1, cnt[i] SHALL increment each cycle and wrap to 0 when it reaches the effective divisor minus 1.
REQ-017 tick[i] SHALL be 1 for exactly the one cycle following the cycle where cnt[i] equals the effective divisor minus 1 with en=1; otherwise 0.
REQ-018 sq[i] SHALL toggle in the same cycle that tick[i] asserts.
REQ-019 With en=0, cnt[i] and sq[i] SHALL hold, and tick SHALL be 0 from the next cycle.
REQ-020 sync=1 SHALL clear every cnt[i] and sq[i] on the next edge, and no tick SHALL assert that cycle; sync overrides en and counting.
REQ-021 load=1 with load_ch<N_CH SHALL write load_div into div[load_ch] and clear cnt[load_ch] on the same edge; other channels are unaffected.
REQ-022 load with load_ch>=N_CH SHALL be ignored with no state change.
REQ-023 When sync and load coincide, both SHALL take effect: all counters clear and the divisor is written.
REQ-024 A load that lowers the divisor below the current count SHALL be safe, because the counter is cleared, so no wrap beyond the new divisor occurs.

Reset
REQ-025 rst=0 SHALL immediately set all cnt to 0, all div to DIV_RST, and tick and sq to all 0, independent of clk.
REQ-026 Reset asserted mid-count SHALL discard the phase; after release, the first tick SHALL follow the full divisor count from 0.

Configuration
REQ-027 Macro TICK_GEN_SQUARE_EN defined SHALL include the sq toggle flops per REQ-018.
REQ-028 Macro TICK_GEN_SQUARE_EN undefined SHALL tie sq to all 0, include no sq flops, and leave tick behaviour unchanged.

Structure
REQ-029 Package tick_gen_pkg SHALL hold the CNT_W default, the channel-index width (4), and the max-channel constant (16).
REQ-030 Per-channel logic (counter, divisor, tick and sq flops) SHALL be one sub-module, tick_gen_ch, instantiated N_CH times by a generate loop; tick_gen owns load decode and sync fan-out.

Verification
REQ-031 Reset, en=1, div[0]=4 via load: tick[0] SHALL pulse at cycles 4, 8, 12 after load, and sq[0] SHALL have period 8.
REQ-032 load_div=0 and load_div=1 on channel 1: tick[1] SHALL be 1 every cycle while en=1.
REQ-033 Channels with divisors 3 and 5, sync pulse at an arbitrary cycle: both channels SHALL tick together 15 cycles after sync, with sq cleared by sync.
REQ-034 en=0 for 10 cycles mid-count with div=6 at cnt=2: no ticks during the pause, and after en=1 the next tick SHALL occur 4 enabled cycles later.
REQ-035 load_ch=N_CH with load_div=7: all divisors and counters SHALL be unchanged and the tick pattern undisturbed.
REQ-036 rst pulsed low between clock edges mid-count: all outputs SHALL be 0 immediately, and the first tick after release SHALL occur at cycle DIV_RST (test using DIV_RST=8).
